x87_memstore_seq: RTL and testbench
===================================

Name: x87_memstore_seq

Overview:
- Downstream of the x87 execution top level. Consumes its registered store pulse (memstore_valid / memstore_size / memstore_data64) together with the effective address supplied by the core.
- Buffers stores in a small FIFO and issues them to the core's 32-bit write path as one or two dword beats under a req/ack handshake.
- Pulses store_done when each store has fully retired, and raises a stall to the core when the buffer is full.

Parameters:
- DEPTH, 2, number of buffered store entries (power of two, 2..8)
- AW, 32, address width

Ports:
- clk  in  1  core clock
- rst  in  1  reset; asynchronous, active-high
- memstore_valid  in  1  one-cycle store pulse from the x87 top level
- memstore_size  in  2  0=word(16b), 1=dword, 2=qword, 3=reserved
- memstore_data64  in  64  store data, LSB-aligned
- st_addr  in  AW  effective address, sampled with memstore_valid
- wr_req  out  1  write request to core write path
- wr_addr  out  AW  beat address
- wr_data  out  32  beat data
- wr_byteena  out  4  beat byte enables
- wr_ack  in  1  write path accepted the current beat
- store_done  out  1  one-cycle pulse when the final beat of a store is acked
- fifo_full  out  1  stall request to core; no new FPU store may issue
- ovf_err  out  1  sticky: a store was dropped (full) or had size 3
- err_clr  in  1  synchronous clear of ovf_err

Behaviour:
- Reset (async, any time, including mid-beat): FIFO empty, FSM=IDLE, all outputs 0. An in-flight beat is abandoned with no store_done.
- Push:
  - memstore_valid with size 0..2 is accepted if count<DEPTH, or if a final-beat ack occurs in the same cycle (pop and push together keep count unchanged).
  - Otherwise the store is dropped and ovf_err is set.
  - Size 3 is always dropped and sets ovf_err.
  - Each entry holds {size, addr, data64}.
- fifo_full = (count==DEPTH), registered.
- FSM states IDLE, BEAT0, BEAT1:
  - IDLE: if the FIFO is non-empty, load the head entry; go to BEAT0 next cycle with wr_req=1. Minimum latency from push to wr_req is 1 cycle when idle and empty.
  - BEAT0:
    - Drives wr_addr=addr, wr_data=data[31:0].
    - wr_byteena is 4'b0011 for word, 4'b1111 otherwise.
    - On wr_ack: word/dword -> pop, store_done=1, then IDLE; qword -> BEAT1.
  - BEAT1:
    - Drives wr_addr=addr+4 (mod 2^AW, wrap allowed), wr_data=data[63:32], wr_byteena=4'b1111.
    - On wr_ack: pop, store_done=1, then IDLE.
  - From IDLE or a completed beat, a new head entry starts BEAT0 on the following cycle, so back-to-back stores have one wr_req-low cycle between them.
- Handshake:
  - wr_req, wr_addr, wr_data and wr_byteena are registered and held stable until the cycle wr_ack is sampled high.
  - wr_req deasserts the cycle after the final ack unless the next beat starts.
  - wr_ack while wr_req=0 is ignored.
- Word store data: wr_data={16'h0,data[15:0]}. Alignment is the write path's responsibility; addr is passed unmodified.
- FIFO order is strict FIFO. Pointers wrap modulo DEPTH.
- err_clr has priority below a same-cycle set: set wins.

Optional Feature:
- X87_MEMSTORE_STATS_EN:
  - When defined, adds output store_count[15:0]. It increments on every store_done and wraps from 16'hFFFF to 0.
  - Adds output drop_count[7:0]. It increments on each dropped store and saturates at 8'hFF.
  - Both counters reset to 0 under rst.
  - When not defined, neither port nor counter logic exists.

Test Plan:
- Dword push, size=1, addr=0x1000, data=0x11223344, wr_ack tied high -> wr_req at cycle+1 with addr 0x1000, data 0x11223344, be 1111; store_done on the ack cycle.
- Qword push, addr=0xFFFFFFFC, data=0xAABBCCDD_01020304, ack delayed 3 cycles per beat -> beat0 (0xFFFFFFFC, 0x01020304) held stable 3 cycles, then beat1 (0x00000000, 0xAABBCCDD); exactly one store_done.
- Word push, data=0x...BEEF -> wr_data 0x0000BEEF, be 0011.
- DEPTH=2 with ack held low, 3 pushes -> fifo_full after the 2nd push, 3rd dropped, ovf_err=1; err_clr clears it. A push coinciding with a final ack while full is accepted.
- Size=3 push -> no wr_req, ovf_err=1.
- Assert rst during BEAT1 -> outputs 0 immediately, no store_done; after release the FIFO is empty.

Source files
------------

// File: rtl/x87_memstore_seq.sv
// x87 store sequencer: buffers FPU store pulses and issues them as one or two dword beats on a req/ack write path.
// Optional X87_MEMSTORE_STATS_EN adds store_count/drop_count statistics outputs.
module x87_memstore_seq #(
    parameter int DEPTH = 2,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          memstore_valid,
    input  logic [1:0]    memstore_size,
    input  logic [63:0]   memstore_data64,
    input  logic [AW-1:0] st_addr,
    output logic          wr_req,
    output logic [AW-1:0] wr_addr,
    output logic [31:0]   wr_data,
    output logic [3:0]    wr_byteena,
    input  logic          wr_ack,
    output logic          store_done,
    output logic          fifo_full,
    output logic          ovf_err,
    input  logic          err_clr
`ifdef X87_MEMSTORE_STATS_EN
    ,
    output logic [15:0]   store_count,
    output logic [7:0]    drop_count
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    localparam logic [1:0] SZ_WORD  = 2'd0;
    localparam logic [1:0] SZ_QWORD = 2'd2;
    localparam logic [1:0] SZ_RSVD  = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        BEAT0,
        BEAT1
    } state_t;

    logic [1:0]    mem_size [DEPTH];
    logic [AW-1:0] mem_addr [DEPTH];
    logic [63:0]   mem_data [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    state_t        state;

    logic [1:0]    cur_size;
    logic [AW-1:0] cur_addr;
    logic [63:0]   cur_data;

    logic [1:0]    head_size;
    logic [AW-1:0] head_addr;
    logic [63:0]   head_data;

    logic final_ack;
    logic push;
    logic drop;
    logic start;

    // A beat is final when it is a BEAT1, or a BEAT0 of anything but a qword.
    assign final_ack = wr_req && wr_ack &&
                       (((state == BEAT0) && (cur_size != SZ_QWORD)) || (state == BEAT1));
    assign push       = memstore_valid && (memstore_size != SZ_RSVD) &&
                        ((count != FULL_CNT) || final_ack);
    assign drop       = memstore_valid && !push;
    assign store_done = final_ack;
    assign start      = (state == IDLE) && ((count != '0) || push);

    // When the buffer is empty the incoming store is also the head, so it can start immediately.
    always_comb begin
        if (count != '0) begin
            head_size = mem_size[rd_ptr];
            head_addr = mem_addr[rd_ptr];
            head_data = mem_data[rd_ptr];
        end else begin
            head_size = memstore_size;
            head_addr = st_addr;
            head_data = memstore_data64;
        end
    end

    always_comb begin
        count_next = count;
        if (push && !final_ack) begin
            count_next = count + CW'(1);
        end else if (!push && final_ack) begin
            count_next = count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_size[wr_ptr] <= memstore_size;
            mem_addr[wr_ptr] <= st_addr;
            mem_data[wr_ptr] <= memstore_data64;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            fifo_full <= 1'b0;
            ovf_err   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (final_ack) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count     <= count_next;
            fifo_full <= (count_next == FULL_CNT);
            if (drop) begin
                ovf_err <= 1'b1;
            end else if (err_clr) begin
                ovf_err <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            wr_req     <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            wr_byteena <= '0;
            cur_size   <= '0;
            cur_addr   <= '0;
            cur_data   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cur_size <= head_size;
                        cur_addr <= head_addr;
                        cur_data <= head_data;
                        wr_req   <= 1'b1;
                        wr_addr  <= head_addr;
                        if (head_size == SZ_WORD) begin
                            wr_data    <= {16'h0000, head_data[15:0]};
                            wr_byteena <= 4'b0011;
                        end else begin
                            wr_data    <= head_data[31:0];
                            wr_byteena <= 4'b1111;
                        end
                        state <= BEAT0;
                    end
                end
                BEAT0: begin
                    if (wr_ack) begin
                        if (cur_size == SZ_QWORD) begin
                            wr_addr    <= cur_addr + AW'(4);
                            wr_data    <= cur_data[63:32];
                            wr_byteena <= 4'b1111;
                            state      <= BEAT1;
                        end else begin
                            wr_req <= 1'b0;
                            state  <= IDLE;
                        end
                    end
                end
                BEAT1: begin
                    if (wr_ack) begin
                        wr_req <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    wr_req <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

`ifdef X87_MEMSTORE_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            store_count <= '0;
            drop_count  <= '0;
        end else begin
            if (final_ack) begin
                store_count <= store_count + 16'd1;
            end
            if (drop && (drop_count != 8'hFF)) begin
                drop_count <= drop_count + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_x87_memstore_seq.sv
// Directed self-checking bench for x87_memstore_seq: expected beats are queued at push time and retired by a beat monitor.
module tb_x87_memstore_seq;

    logic        clk;
    logic        rst;
    logic        memstore_valid;
    logic [1:0]  memstore_size;
    logic [63:0] memstore_data64;
    logic [31:0] st_addr;
    logic        wr_req;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_byteena;
    logic        wr_ack;
    logic        store_done;
    logic        fifo_full;
    logic        ovf_err;
    logic        err_clr;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic        last;
    } beat_t;

    beat_t exp_q[$];
    int checks = 0;
    int errors = 0;
    int done_seen = 0;
    int exp_done = 0;

    x87_memstore_seq #(.DEPTH(2), .AW(32)) dut (
        .clk(clk), .rst(rst),
        .memstore_valid(memstore_valid), .memstore_size(memstore_size),
        .memstore_data64(memstore_data64), .st_addr(st_addr),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_byteena(wr_byteena),
        .wr_ack(wr_ack), .store_done(store_done), .fifo_full(fifo_full),
        .ovf_err(ovf_err), .err_clr(err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model of how a store is split into beats.
    task automatic exp_store(input logic [1:0] size, input logic [31:0] addr, input logic [63:0] d);
        beat_t b;
        b.addr = addr;
        b.last = (size != 2'd2);
        if (size == 2'd0) begin
            b.data = {16'h0000, d[15:0]};
            b.be   = 4'b0011;
        end else begin
            b.data = d[31:0];
            b.be   = 4'b1111;
        end
        exp_q.push_back(b);
        if (size == 2'd2) begin
            b.addr = addr + 32'd4;
            b.data = d[63:32];
            b.be   = 4'b1111;
            b.last = 1'b1;
            exp_q.push_back(b);
        end
        exp_done++;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (wr_req) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 64'(wr_addr), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    chk("beat_addr", 64'(wr_addr), 64'(exp_q[0].addr));
                    chk("beat_data", 64'(wr_data), 64'(exp_q[0].data));
                    chk("beat_be", 64'(wr_byteena), 64'(exp_q[0].be));
                    if (wr_ack) begin
                        chk("store_done_ack", 64'(store_done), 64'(exp_q[0].last));
                        void'(exp_q.pop_front());
                    end else begin
                        chk("store_done_wait", 64'(store_done), 64'd0);
                    end
                end
            end else begin
                chk("store_done_noreq", 64'(store_done), 64'd0);
            end
            if (store_done) done_seen++;
        end
    end

    task automatic push(input logic [1:0] size, input logic [31:0] addr, input logic [63:0] d);
        memstore_valid  = 1'b1;
        memstore_size   = size;
        st_addr         = addr;
        memstore_data64 = d;
        @(posedge clk); #1;
        memstore_valid  = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Waits (bounded) for a request, then acks on the n-th cycle it is held.
    task automatic ack_beat(input int n);
        int t = 0;
        while (!wr_req && t < 20) begin @(posedge clk); #1; t++; end
        chk("req_timeout", 64'(wr_req), 64'd1);
        repeat (n - 1) begin @(posedge clk); #1; end
        wr_ack = 1'b1;
        @(posedge clk); #1;
        wr_ack = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; memstore_valid = 1'b0; memstore_size = 2'd0; memstore_data64 = '0;
        st_addr = '0; wr_ack = 1'b0; err_clr = 1'b0;
        cycles(3);
        chk("rst_wr_req", 64'(wr_req), 64'd0);
        chk("rst_fifo_full", 64'(fifo_full), 64'd0);
        chk("rst_ovf_err", 64'(ovf_err), 64'd0);
        chk("rst_wr_be", 64'(wr_byteena), 64'd0);
        rst = 1'b0;
        cycles(2);

        // Dword with ack tied high: request one cycle after the push.
        wr_ack = 1'b1;
        exp_store(2'd1, 32'h0000_1000, 64'h0000_0000_1122_3344);
        push(2'd1, 32'h0000_1000, 64'h0000_0000_1122_3344);
        chk("dword_latency", 64'(wr_req), 64'd1);
        cycles(4);
        chk("dword_done", 64'(done_seen), 64'(exp_done));
        wr_ack = 1'b0;

        // Qword wrapping the address, ack on the third cycle of each beat.
        exp_store(2'd2, 32'hFFFF_FFFC, 64'hAABB_CCDD_0102_0304);
        push(2'd2, 32'hFFFF_FFFC, 64'hAABB_CCDD_0102_0304);
        ack_beat(3);
        chk("qword_beat1_req", 64'(wr_req), 64'd1);
        chk("qword_no_early_done", 64'(done_seen), 64'(exp_done - 1));
        ack_beat(3);
        cycles(2);
        chk("qword_done", 64'(done_seen), 64'(exp_done));
        chk("qword_req_drop", 64'(wr_req), 64'd0);

        // Word store.
        wr_ack = 1'b1;
        exp_store(2'd0, 32'h0000_2002, 64'h5566_7788_1234_BEEF);
        push(2'd0, 32'h0000_2002, 64'h5566_7788_1234_BEEF);
        cycles(3);
        chk("word_done", 64'(done_seen), 64'(exp_done));
        wr_ack = 1'b0;

        // Fill with ack low, overflow, clear, then push alongside a final ack while full.
        exp_store(2'd1, 32'h0000_3000, 64'h0000_0000_A0A0_A0A0);
        push(2'd1, 32'h0000_3000, 64'h0000_0000_A0A0_A0A0);
        chk("fill1_full", 64'(fifo_full), 64'd0);
        exp_store(2'd1, 32'h0000_3004, 64'h0000_0000_B1B1_B1B1);
        push(2'd1, 32'h0000_3004, 64'h0000_0000_B1B1_B1B1);
        chk("fill2_full", 64'(fifo_full), 64'd1);
        push(2'd1, 32'h0000_3008, 64'h0000_0000_C2C2_C2C2);
        chk("drop_ovf", 64'(ovf_err), 64'd1);
        chk("drop_still_full", 64'(fifo_full), 64'd1);
        err_clr = 1'b1;
        cycles(1);
        err_clr = 1'b0;
        chk("err_clr", 64'(ovf_err), 64'd0);
        wr_ack = 1'b1;
        exp_store(2'd1, 32'h0000_300C, 64'h0000_0000_D3D3_D3D3);
        push(2'd1, 32'h0000_300C, 64'h0000_0000_D3D3_D3D3);
        chk("pushpop_full", 64'(fifo_full), 64'd1);
        chk("pushpop_no_ovf", 64'(ovf_err), 64'd0);
        cycles(10);
        chk("drain_done", 64'(done_seen), 64'(exp_done));
        chk("drain_empty", 64'(fifo_full), 64'd0);
        chk("drain_queue", 64'(exp_q.size()), 64'd0);
        wr_ack = 1'b0;

        // Reserved size is dropped; a same-cycle clear loses to the set.
        err_clr = 1'b1;
        push(2'd3, 32'h0000_4000, 64'h1);
        err_clr = 1'b0;
        chk("size3_ovf", 64'(ovf_err), 64'd1);
        cycles(3);
        chk("size3_no_req", 64'(wr_req), 64'd0);
        err_clr = 1'b1;
        cycles(1);
        err_clr = 1'b0;
        chk("size3_clr", 64'(ovf_err), 64'd0);

        // Reset in the middle of the second beat of a qword.
        exp_store(2'd2, 32'h0000_5000, 64'h7777_6666_5555_4444);
        exp_done--;
        push(2'd2, 32'h0000_5000, 64'h7777_6666_5555_4444);
        ack_beat(1);
        chk("pre_rst_beat1", 64'(wr_addr), 64'h5004);
        #1 rst = 1'b1;
        #1;
        chk("rst_mid_req", 64'(wr_req), 64'd0);
        chk("rst_mid_done", 64'(store_done), 64'd0);
        chk("rst_mid_addr", 64'(wr_addr), 64'd0);
        chk("rst_mid_data", 64'(wr_data), 64'd0);
        exp_q.delete();
        cycles(2);
        rst = 1'b0;
        cycles(3);
        chk("post_rst_req", 64'(wr_req), 64'd0);
        chk("post_rst_full", 64'(fifo_full), 64'd0);
        chk("post_rst_done", 64'(done_seen), 64'(exp_done));
        wr_ack = 1'b1;
        exp_store(2'd1, 32'h0000_6000, 64'h0000_0000_CAFE_F00D);
        push(2'd1, 32'h0000_6000, 64'h0000_0000_CAFE_F00D);
        cycles(3);
        chk("post_rst_store", 64'(done_seen), 64'(exp_done));
        chk("final_queue", 64'(exp_q.size()), 64'd0);
        wr_ack = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
